// File: rtl/pcm_ecc_pkg.sv
// Shared codes and state encoding for the PUF ECC engine scheduler.
package pcm_ecc_pkg;

  // Instruction codes understood by the ECC engine
  localparam logic [1:0] ECC_IDLE      = 2'b00;
  localparam logic [1:0] ECC_PROVISION = 2'b01;
  localparam logic [1:0] ECC_CORRECT   = 2'b10;

  // Completion status returned to requesters
  localparam logic [1:0] RSP_OK        = 2'b00;
  localparam logic [1:0] RSP_TIMEOUT   = 2'b01;
  localparam logic [1:0] RSP_UNPROV    = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    REJECT,
    ISSUE,
    WAIT,
    RELEASE,
    DRAIN
  } sched_state_t;

  // Requester op bit (0 = provision, 1 = correct) to engine instruction
  function automatic logic [1:0] op_code(input logic op);
    return op ? ECC_CORRECT : ECC_PROVISION;
  endfunction

endpackage

// File: rtl/pcm_rr_arbiter.sv
// Combinational round-robin picker: first active request at or after ptr, wrapping.
module pcm_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan N positions starting at ptr; the first requester found wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[(int'(ptr) + k) % N]) begin
        any                       = 1'b1;
        grant[(int'(ptr) + k) % N] = 1'b1;
        idx                       = IW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/pcm_ecc_scheduler.sv
// Shares one PUF ECC engine among N_REQ requesters: round-robin grant,
// engine instruction/valid sequencing, timeout, and provisioned-IPID tracking.
module pcm_ecc_scheduler
  import pcm_ecc_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int SIG_W       = 256,
  parameter int IPID_N      = 16,
  parameter int TIMEOUT_CYC = 64,
  localparam int IPW        = $clog2(IPID_N)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0]       req_op,
  input  logic [N_REQ*IPW-1:0]   req_ipid,
  input  logic [N_REQ*SIG_W-1:0] req_sig,
  output logic [N_REQ-1:0]       req_grant,
  output logic [N_REQ-1:0]       rsp_done,
  output logic [SIG_W-1:0]       rsp_sig,
  output logic [1:0]             rsp_status,
  output logic                   busy,
  output logic [1:0]             ecc_instruction,
  output logic [SIG_W-1:0]       ecc_puf_in,
  output logic                   ecc_puf_in_valid,
  output logic [IPW-1:0]         ecc_ipid_number,
  input  logic [SIG_W-1:0]       ecc_puf_out,
  input  logic                   ecc_puf_out_valid,
  input  logic                   ecc_S_c
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  sched_state_t     state;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    gnt_idx;
  logic             op_q;
  logic             timed_out;
  logic [TW-1:0]    timer;
  logic [IPID_N-1:0] prov_map;

  logic [N_REQ-1:0] arb_grant;
  logic [IW-1:0]    arb_idx;
  logic             arb_any;
  logic             sel_op;
  logic [IPW-1:0]   sel_ipid;
  logic [SIG_W-1:0] sel_sig;
  logic             done_evt;

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] i);
    return (i == IW'(N_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  function automatic logic [N_REQ-1:0] idx_onehot(input logic [IW-1:0] i);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  pcm_rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // Operands of the requester the arbiter currently favours
  assign sel_op   = req_op[arb_idx];
  assign sel_ipid = req_ipid[arb_idx*IPW +: IPW];
  assign sel_sig  = req_sig[arb_idx*SIG_W +: SIG_W];

  // Provision completes on storage-complete, correction on output-valid
  assign done_evt = op_q ? ecc_puf_out_valid : ecc_S_c;

  // Grant is a same-cycle pulse in IDLE; forced low while reset is held
  assign req_grant = (state == IDLE && rst_n) ? arb_grant : '0;
  assign busy      = (state != IDLE);

  // Scheduler FSM; every engine and response output is registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      rr_ptr           <= '0;
      gnt_idx          <= '0;
      op_q             <= 1'b0;
      timed_out        <= 1'b0;
      timer            <= '0;
      prov_map         <= '0;
      rsp_done         <= '0;
      rsp_sig          <= '0;
      rsp_status       <= RSP_OK;
      ecc_instruction  <= ECC_IDLE;
      ecc_puf_in       <= '0;
      ecc_puf_in_valid <= 1'b0;
      ecc_ipid_number  <= '0;
    end else begin
      rsp_done <= '0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            gnt_idx         <= arb_idx;
            op_q            <= sel_op;
            timer           <= '0;
            timed_out       <= 1'b0;
            ecc_ipid_number <= sel_ipid;
            ecc_puf_in      <= sel_sig;
            // Correcting an IPID with no stored parity never reaches the engine
            if (sel_op && !prov_map[sel_ipid]) begin
              state      <= REJECT;
              rsp_done   <= arb_grant;
              rsp_status <= RSP_UNPROV;
              rsp_sig    <= '0;
            end else begin
              state            <= ISSUE;
              ecc_instruction  <= op_code(sel_op);
              ecc_puf_in_valid <= 1'b1;
            end
          end
        end
        REJECT: begin
          // Advance the pointer here too so a held unprovisioned request cannot starve others
          state  <= IDLE;
          rr_ptr <= next_ptr(gnt_idx);
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (done_evt) begin
            if (op_q) rsp_sig <= ecc_puf_out;
            state           <= RELEASE;
            ecc_instruction <= ECC_IDLE;
          end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
            timed_out       <= 1'b1;
            state           <= RELEASE;
            ecc_instruction <= ECC_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RELEASE: begin
          // Engine leaves its op state only while valid is still high; drop it now
          ecc_puf_in_valid <= 1'b0;
          state            <= DRAIN;
          rsp_done         <= idx_onehot(gnt_idx);
          rsp_status       <= timed_out ? RSP_TIMEOUT : RSP_OK;
          if (!op_q && !timed_out) prov_map[ecc_ipid_number] <= 1'b1;
        end
        DRAIN: begin
          // Extra cycle lets the engine's late-clearing S_c/out_valid fall
          state  <= IDLE;
          rr_ptr <= next_ptr(gnt_idx);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcm_ecc_scheduler.sv
// Randomized bench for pcm_ecc_scheduler with a behavioural ECC engine and a
// transaction-level reference model (provisioned set, round-robin pointer).
module tb_pcm_ecc_scheduler;
  import pcm_ecc_pkg::*;

  localparam int N_REQ       = 4;
  localparam int SIG_W       = 256;
  localparam int IPID_N      = 16;
  localparam int TIMEOUT_CYC = 64;
  localparam int IPW         = $clog2(IPID_N);
  localparam int SW          = SIG_W;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_op;
  logic [N_REQ*IPW-1:0]   req_ipid;
  logic [N_REQ*SIG_W-1:0] req_sig;
  logic [N_REQ-1:0]       req_grant;
  logic [N_REQ-1:0]       rsp_done;
  logic [SIG_W-1:0]       rsp_sig;
  logic [1:0]             rsp_status;
  logic                   busy;
  logic [1:0]             ecc_instruction;
  logic [SIG_W-1:0]       ecc_puf_in;
  logic                   ecc_puf_in_valid;
  logic [IPW-1:0]         ecc_ipid_number;
  logic [SIG_W-1:0]       ecc_puf_out;
  logic                   ecc_puf_out_valid;
  logic                   ecc_S_c;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit               m_prov [IPID_N];
  logic [SIG_W-1:0] m_sig  [IPID_N];
  int               m_ptr;

  // Engine environment state
  logic [SIG_W-1:0] eng_mem [IPID_N];
  int               eng_cnt;
  bit               eng_stub;

  always #5 clk = ~clk;

  pcm_ecc_scheduler #(
    .N_REQ(N_REQ), .SIG_W(SIG_W), .IPID_N(IPID_N), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid         (req_valid),
    .req_op            (req_op),
    .req_ipid          (req_ipid),
    .req_sig           (req_sig),
    .req_grant         (req_grant),
    .rsp_done          (rsp_done),
    .rsp_sig           (rsp_sig),
    .rsp_status        (rsp_status),
    .busy              (busy),
    .ecc_instruction   (ecc_instruction),
    .ecc_puf_in        (ecc_puf_in),
    .ecc_puf_in_valid  (ecc_puf_in_valid),
    .ecc_ipid_number   (ecc_ipid_number),
    .ecc_puf_out       (ecc_puf_out),
    .ecc_puf_out_valid (ecc_puf_out_valid),
    .ecc_S_c           (ecc_S_c)
  );

  // Behavioural engine: answers on the second cycle of an instruction, clears one cycle after IDLE
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_cnt           <= 0;
      ecc_S_c           <= 1'b0;
      ecc_puf_out_valid <= 1'b0;
      ecc_puf_out       <= '0;
    end else if (ecc_instruction == ECC_IDLE) begin
      eng_cnt           <= 0;
      ecc_S_c           <= 1'b0;
      ecc_puf_out_valid <= 1'b0;
    end else if (ecc_puf_in_valid && !eng_stub) begin
      if (eng_cnt == 0) begin
        eng_cnt <= 1;
      end else if (eng_cnt == 1) begin
        eng_cnt <= 2;
        if (ecc_instruction == ECC_PROVISION) begin
          eng_mem[ecc_ipid_number] <= ecc_puf_in;
          ecc_S_c                  <= 1'b1;
        end else begin
          ecc_puf_out <= ($countones(ecc_puf_in ^ eng_mem[ecc_ipid_number]) <= 1)
                         ? eng_mem[ecc_ipid_number] : ecc_puf_in;
          ecc_puf_out_valid <= 1'b1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic op, input logic [IPW-1:0] ip,
                         input logic [SIG_W-1:0] s);
    req_op[i]               = op;
    req_ipid[i*IPW +: IPW]  = ip;
    req_sig[i*SIG_W +: SIG_W] = s;
  endtask

  task automatic rand_sig(output logic [SIG_W-1:0] s);
    for (int b = 0; b < SIG_W / 32; b++) s[b*32 +: 32] = $urandom();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"}, SW'(req_grant), '0);
    check({tag, "_done"}, SW'(rsp_done), '0);
    check({tag, "_busy"}, SW'(busy), '0);
    check({tag, "_instr"}, SW'(ecc_instruction), '0);
    check({tag, "_inval"}, SW'(ecc_puf_in_valid), '0);
    check({tag, "_pufin"}, ecc_puf_in, '0);
    check({tag, "_ipid"}, SW'(ecc_ipid_number), '0);
    check({tag, "_sig"}, rsp_sig, '0);
    check({tag, "_status"}, SW'(rsp_status), '0);
  endtask

  // One transaction: requests already driven at a negedge; hold keeps req_valid up afterwards
  task automatic txn(input bit hold, input bit stub);
    int w, n, cyc, exp_lat;
    bit rej, opw, overlap;
    logic [IPW-1:0]   ipw;
    logic [SIG_W-1:0] sgw;
    logic [1:0]       exp_st;
    eng_stub = stub;
    #1;
    n = 0;
    while (req_grant == '0 && n < 10) begin
      @(negedge clk); #1; n++;
    end
    w = 0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req_valid[(m_ptr + k) % N_REQ]) w = (m_ptr + k) % N_REQ;
    check("grant", SW'(req_grant), SW'(1) << w);
    opw     = req_op[w];
    ipw     = req_ipid[w*IPW +: IPW];
    sgw     = req_sig[w*SIG_W +: SIG_W];
    rej     = opw && !m_prov[ipw];
    exp_st  = rej ? RSP_UNPROV : (stub ? RSP_TIMEOUT : RSP_OK);
    exp_lat = rej ? 1 : (stub ? TIMEOUT_CYC + 3 : 5);
    @(negedge clk); #1;
    if (!hold) req_valid = '0;
    cyc = 1;
    check("instr_c1", SW'(ecc_instruction),
          SW'(rej ? ECC_IDLE : (opw ? ECC_CORRECT : ECC_PROVISION)));
    check("inval_c1", SW'(ecc_puf_in_valid), SW'(!rej));
    check("busy_c1", SW'(busy), SW'(1));
    if (!rej) begin
      check("ipid_c1", SW'(ecc_ipid_number), SW'(ipw));
      check("pufin_c1", ecc_puf_in, sgw);
    end
    overlap = 1'b0;
    while (rsp_done == '0 && cyc < TIMEOUT_CYC + 20) begin
      @(negedge clk); #1; cyc++;
      if (req_grant != '0) overlap = 1'b1;
      if (!rej && cyc == exp_lat - 1) begin
        check("instr_release", SW'(ecc_instruction), SW'(ECC_IDLE));
        check("inval_release", SW'(ecc_puf_in_valid), SW'(1));
        check("pufin_release", ecc_puf_in, sgw);
      end
    end
    check("latency", SW'(cyc), SW'(exp_lat));
    check("done", SW'(rsp_done), SW'(1) << w);
    check("status", SW'(rsp_status), SW'(exp_st));
    check("no_overlap", SW'(overlap), '0);
    if (opw && exp_st == RSP_OK) check("sig", rsp_sig, m_sig[ipw]);
    if (rej) check("sig_reject", rsp_sig, '0);
    if (!opw && exp_st == RSP_OK) begin
      m_prov[ipw] = 1'b1;
      m_sig[ipw]  = sgw;
    end
    m_ptr = (w + 1) % N_REQ;
    @(negedge clk); #1;
    check("done_pulse", SW'(rsp_done), '0);
    check("busy_after", SW'(busy), '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SIG_W-1:0] a5, s;
    logic [3:0]       mask;
    logic             op;
    logic [IPW-1:0]   ip;
    a5        = {(SIG_W / 8){8'hA5}};
    rst_n     = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_ipid  = '0;
    req_sig   = '0;
    eng_stub  = 1'b0;
    m_ptr     = 0;
    for (int i = 0; i < IPID_N; i++) begin m_prov[i] = 1'b0; m_sig[i] = '0; end
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Provision ipid 3, then correct it with one bit flipped
    @(negedge clk);
    set_req(0, 1'b0, 4'd3, a5);
    req_valid = 4'b0001;
    txn(0, 0);
    @(negedge clk);
    set_req(0, 1'b1, 4'd3, a5 ^ (SW'(1) << 17));
    req_valid = 4'b0001;
    txn(0, 0);

    // Correct on a never-provisioned IPID is rejected without the engine
    @(negedge clk);
    set_req(1, 1'b1, 4'd7, a5);
    req_valid = 4'b0010;
    txn(0, 0);

    // All requesters held: round-robin order, one transaction each
    @(negedge clk);
    for (int i = 0; i < N_REQ; i++) begin
      rand_sig(s);
      set_req(i, 1'b0, IPW'(11 + i), s);
    end
    req_valid = 4'b1111;
    for (int t = 0; t < 5; t++) txn(t < 4, 0);

    // Engine never completes: timeout, and the IPID stays unprovisioned
    @(negedge clk);
    rand_sig(s);
    set_req(2, 1'b0, 4'd9, s);
    req_valid = 4'b0100;
    txn(0, 1);
    eng_stub = 1'b0;
    @(negedge clk);
    set_req(2, 1'b1, 4'd9, s);
    req_valid = 4'b0100;
    txn(0, 0);

    // Reset in the middle of WAIT abandons the transaction
    @(negedge clk);
    rand_sig(s);
    set_req(0, 1'b0, 4'd10, s);
    req_valid = 4'b0001;
    eng_stub  = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("midrst_wait_busy", SW'(busy), SW'(1));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      check("midrst_no_done", SW'(rsp_done), '0);
    end
    req_valid = '0;
    eng_stub  = 1'b0;
    m_ptr     = 0;
    for (int i = 0; i < IPID_N; i++) m_prov[i] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rand_sig(s);
    set_req(3, 1'b0, 4'd5, s);
    req_valid = 4'b1000;
    txn(0, 0);
    @(negedge clk);
    set_req(3, 1'b1, 4'd5, s ^ (SW'(1) << 200));
    req_valid = 4'b1000;
    txn(0, 0);

    // Randomized mix of requesters, ops and IPIDs
    for (int it = 0; it < 40; it++) begin
      @(negedge clk);
      for (int i = 0; i < N_REQ; i++) begin
        op = 1'($urandom_range(0, 1));
        ip = IPW'($urandom_range(0, 7));
        rand_sig(s);
        if (op && m_prov[ip]) begin
          s = m_sig[ip];
          if ($urandom_range(0, 1) == 1) s[$urandom_range(0, SIG_W - 1)] ^= 1'b1;
        end
        set_req(i, op, ip, s);
      end
      mask      = 4'($urandom_range(1, 15));
      req_valid = mask;
      txn(0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
